// File: rtl/alarm_leds_pio_pkg.sv
// Shared register map for the alarm LED/buzzer output port.
// Word addresses and STATUS bit positions used by the top level and the bench.
package alarm_leds_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

    localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/alarm_blink_timer.sv
// Blink half-period timer: holds the period register, a cycle counter and the phase bit.
// A zero period parks the phase at 1 so masked outputs stay steady.
module alarm_blink_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                period_we,
    input  logic [PERIOD_W-1:0] period_wdata,
    output logic                phase,
    output logic [PERIOD_W-1:0] period
);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                phase_q;

    // A period write restarts the half-period and wins over a coincident wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else if (period_we) begin
            period_q <= period_wdata;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else if (period_q == '0) begin
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
            cnt_q    <= '0;
            phase_q  <= ~phase_q;
        end else begin
            cnt_q    <= cnt_q + PERIOD_W'(1);
        end
    end

    assign phase  = phase_q;
    assign period = period_q;

endmodule

// File: rtl/alarm_leds_pio.sv
// Avalon-MM writable output port driving the alarm LEDs/buzzer, with atomic
// set/clear registers and a per-bit hardware blink mask.
module alarm_leds_pio
    import alarm_leds_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PERIOD_W    = 24,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                wr_en;
    logic [WIDTH-1:0]    wd;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    out_d;
    logic [31:0]         readdata_d;
    logic                period_we;
    logic                phase;
    logic [PERIOD_W-1:0] period;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign period_we = wr_en && (address == ADDR_PERIOD);

    alarm_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk          (clk),
        .reset        (reset),
        .period_we    (period_we),
        .period_wdata (writedata[PERIOD_W-1:0]),
        .phase        (phase),
        .period       (period)
    );

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wd;
                ADDR_MASK:     mask_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default: ;
            endcase
        end
    end

    // Read mux runs every cycle regardless of chipselect; write-only addresses read 0.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d[WIDTH-1:0]        = data_q;
            ADDR_MASK:   readdata_d[WIDTH-1:0]        = mask_q;
            ADDR_PERIOD: readdata_d[PERIOD_W-1:0]     = period;
            ADDR_STATUS: readdata_d[STATUS_PHASE_BIT] = phase;
            default: ;
        endcase
    end

    assign out_d = data_q & ~(mask_q & {WIDTH{~phase}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            mask_q   <= '0;
            readdata <= '0;
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            readdata <= readdata_d;
            out_port <= out_d;
        end
    end

endmodule

// File: tb/tb_alarm_leds_pio.sv
// Directed self-checking bench for alarm_leds_pio (WIDTH=4, RESET_VALUE=4'h5).
module tb_alarm_leds_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic [31:0] rd;
    logic        exp_ph;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    alarm_leds_pio #(
        .WIDTH       (4),
        .PERIOD_W    (24),
        .RESET_VALUE (32'h5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write is accepted on the next rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // 1: reset values and DATA readback
        repeat (2) @(negedge clk);
        check("rst_out", {28'h0, out_port}, 32'h5);
        check("rst_rd", readdata, 32'h0);
        reset = 1'b0;
        bus_read(3'd0, rd);
        check("rd_data_rst", rd, 32'h5);

        // 2: DATA, OUTSET, OUTCLEAR
        bus_write(3'd0, 32'hA);
        bus_write(3'd3, 32'h1);
        bus_write(3'd4, 32'h8);
        check("out_lag", {28'h0, out_port}, 32'hB);
        @(negedge clk);
        check("out_setclr", {28'h0, out_port}, 32'h3);
        bus_read(3'd0, rd);
        check("rd_data_setclr", rd, 32'h3);
        bus_read(3'd3, rd);
        check("rd_outset_zero", rd, 32'h0);
        bus_read(3'd4, rd);
        check("rd_outclr_zero", rd, 32'h0);

        // 3: blink bit 0 with half-period 3; period write accepted at edge E0
        bus_write(3'd0, 32'hF);
        bus_write(3'd1, 32'h1);
        bus_read(3'd1, rd);
        check("rd_mask", rd, 32'h1);
        bus_write(3'd2, 32'h3);
        address = 3'd5;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp_ph = (((k - 1) / 3) % 2) == 0;
            if (k <= 9) begin
                check("blink3_out", {28'h0, out_port}, {28'h0, 3'b111, exp_ph});
                check("blink3_status", readdata, {31'h0, exp_ph});
            end
        end

        // 4: period write on the wrap edge E15 that would otherwise clear phase
        bus_write(3'd2, 32'h5);
        address = 3'd5;
        check("wrap_out_pre", {28'h0, out_port}, 32'hF);
        for (int k = 16; k <= 21; k++) begin
            @(negedge clk);
            exp_ph = (k <= 20);
            check("blink5_out", {28'h0, out_port}, {28'h0, 3'b111, exp_ph});
            check("blink5_status", readdata, {31'h0, exp_ph});
        end

        // 5: period 0 written while phase is 0
        bus_write(3'd2, 32'h0);
        check("dis_out_pre", {28'h0, out_port}, 32'hE);
        address = 3'd5;
        for (int k = 23; k <= 28; k++) begin
            @(negedge clk);
            check("dis_out", {28'h0, out_port}, 32'hF);
            check("dis_status", readdata, 32'h1);
        end

        // 6: asynchronous reset mid-period, with phase at 0
        bus_write(3'd2, 32'h4);
        repeat (5) @(negedge clk);
        check("pre_rst_out", {28'h0, out_port}, 32'hE);
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", {28'h0, out_port}, 32'h5);
        check("async_rst_rd", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(3'd1, rd);
        check("post_rst_mask", rd, 32'h0);
        bus_read(3'd2, rd);
        check("post_rst_period", rd, 32'h0);
        bus_read(3'd5, rd);
        check("post_rst_status", rd, 32'h1);
        bus_read(3'd0, rd);
        check("post_rst_data", rd, 32'h5);
        repeat (6) @(negedge clk);
        check("post_rst_out", {28'h0, out_port}, 32'h5);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
